// File: rtl/tour_distance_engine.sv
// Streams tour city indices and sums leg distances, plus the closing leg, from a
// runtime-loaded triangular distance table. Optional edge counter: TDE_EDGE_COUNT_EN.
module tour_distance_engine #(
  parameter int CITY_W       = 5,
  parameter int NUM_CITIES   = 30,
  parameter int DIST_W       = 10,
  parameter int SUM_W        = 16,
  parameter int DEFAULT_DIST = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CITY_W-1:0] cfg_a,
  input  logic [CITY_W-1:0] cfg_b,
  input  logic [DIST_W-1:0] cfg_dist,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CITY_W-1:0] in_city,
  input  logic              in_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_sat,
  output logic              idx_err,
  output logic              busy
`ifdef TDE_EDGE_COUNT_EN
  ,
  output logic [15:0]       edge_count
`endif
);

  localparam int ENTRIES = NUM_CITIES * (NUM_CITIES - 1) / 2;
  localparam int AD_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int ACC_W   = ((SUM_W > DIST_W) ? SUM_W : DIST_W) + 1;
  localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'({SUM_W{1'b1}});

  typedef enum logic [2:0] {IDLE, ACCUM, CLOSE, FLUSH, DONE} state_t;

  function automatic logic is_legal(input logic [CITY_W-1:0] c);
    return ({1'b0, c} < (CITY_W+1)'(NUM_CITIES));
  endfunction

  function automatic logic [AD_W-1:0] tri_addr(input logic [CITY_W-1:0] a,
                                               input logic [CITY_W-1:0] b);
    logic [CITY_W-1:0]   lo;
    logic [CITY_W-1:0]   hi;
    logic [2*CITY_W-1:0] prod;
    lo   = (a < b) ? a : b;
    hi   = (a < b) ? b : a;
    prod = ((2*CITY_W)'(hi) * (2*CITY_W)'(hi - 1'b1)) >> 1;
    return AD_W'(prod + (2*CITY_W)'(lo));
  endfunction

  state_t              r_state, w_state_nxt;
  logic [CITY_W-1:0]   r_first, r_prev;
  logic [SUM_W-1:0]    r_sum;
  logic                r_sat, r_idx, r_cfg_err;
  logic                r_rd_pend, r_rd_zero, r_rd_def, r_rd_hit;
  logic [DIST_W-1:0]   r_rd_data;
  logic [DIST_W-1:0]   r_mem [ENTRIES];
  logic [ENTRIES-1:0]  r_tbl_vld;
  logic [15:0]         r_edge_cnt;

  logic                w_acc, w_wr_ok, w_lk, w_lk_legal, w_lk_same, w_ovf;
  logic [CITY_W-1:0]   w_la, w_lb;
  logic [AD_W-1:0]     w_raddr, w_waddr;
  logic [DIST_W-1:0]   w_dist;
  logic [ACC_W-1:0]    w_add;

  assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign sum_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign sum_sat   = r_sat;
  assign idx_err   = r_idx;
  assign cfg_err   = r_cfg_err;
  assign w_acc     = in_valid && in_ready;

  // Writes land only while idle so they never race a tour's lookups.
  assign w_wr_ok = cfg_we && !busy && is_legal(cfg_a) && is_legal(cfg_b) && (cfg_a != cfg_b);
  assign w_waddr = tri_addr(cfg_a, cfg_b);

  always_comb begin
    w_lk = 1'b0;
    w_la = r_prev;
    w_lb = in_city;
    if (r_state == ACCUM && w_acc) begin
      w_lk = 1'b1;
    end else if (r_state == CLOSE) begin
      w_lk = 1'b1;
      w_lb = r_first;
    end
  end

  assign w_lk_legal = is_legal(w_la) && is_legal(w_lb);
  assign w_lk_same  = (w_la == w_lb);
  assign w_raddr    = (w_lk_legal && !w_lk_same) ? tri_addr(w_la, w_lb) : '0;

  // Data array carries no reset; the valid bits decide whether it is trusted.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= cfg_dist;
    r_rd_data <= r_mem[w_raddr];
  end

  always_comb begin
    w_dist = r_rd_data;
    if (r_rd_zero)                  w_dist = '0;
    else if (r_rd_def || !r_rd_hit) w_dist = DIST_W'(DEFAULT_DIST);
  end

  assign w_add = ACC_W'(r_sum) + ACC_W'(w_dist);
  assign w_ovf = (w_add > SUM_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = in_last ? CLOSE : ACCUM;
      ACCUM:   if (w_acc && in_last) w_state_nxt = CLOSE;
      CLOSE:   w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = DONE;
      DONE:    if (sum_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl_vld <= '0;
      r_cfg_err <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_zero <= 1'b0;
      r_rd_def  <= 1'b0;
      r_rd_hit  <= 1'b0;
    end else begin
      if (w_wr_ok) r_tbl_vld[w_waddr] <= 1'b1;
      r_cfg_err <= cfg_we && !w_wr_ok;
      r_rd_pend <= w_lk;
      r_rd_def  <= !w_lk_legal;
      r_rd_zero <= w_lk_legal && w_lk_same;
      r_rd_hit  <= r_tbl_vld[w_raddr];
    end
  end

  // Tour accumulator: one registered lookup lands per cycle after it was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first    <= '0;
      r_prev     <= '0;
      r_sum      <= '0;
      r_sat      <= 1'b0;
      r_idx      <= 1'b0;
      r_edge_cnt <= '0;
    end else if (r_state == IDLE && w_acc) begin
      r_first    <= in_city;
      r_prev     <= in_city;
      r_sum      <= '0;
      r_sat      <= 1'b0;
      r_idx      <= !is_legal(in_city);
      r_edge_cnt <= '0;
    end else begin
      if (r_state == ACCUM && w_acc) begin
        r_prev <= in_city;
        if (!is_legal(in_city)) r_idx <= 1'b1;
      end
      if (r_rd_pend) begin
        if (w_ovf) begin
          r_sum <= '1;
          r_sat <= 1'b1;
        end else begin
          r_sum <= SUM_W'(w_add);
        end
        if (r_edge_cnt != 16'hFFFF) r_edge_cnt <= r_edge_cnt + 16'd1;
      end
    end
  end

`ifdef TDE_EDGE_COUNT_EN
  assign edge_count = r_edge_cnt;
`else
  logic w_unused_edge;
  assign w_unused_edge = ^r_edge_cnt;
`endif

endmodule

// File: doc/tour_distance_engine.md
Name: tour_distance_engine

Overview:
Sequential tour-length calculator for the GA fitness stage. It replaces the hard-coded city-pair distance lookup with a runtime-loadable symmetric distance table sized by parameter. It streams a tour's city indices, sums the leg distances, and adds the closing leg from the last city back to the first. The result is presented on a valid/ready output that feeds fitness ranking.

Parameters:
- CITY_W, 5, city index width
- NUM_CITIES, 30, number of legal cities (≤ 2^CITY_W); indices ≥ NUM_CITIES are illegal
- DIST_W, 10, width of one pair distance
- SUM_W, 16, width of the tour-length accumulator
- DEFAULT_DIST, 5, distance returned for a pair never written since reset, or for an illegal index

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_a  in  CITY_W  write city A
- cfg_b  in  CITY_W  write city B
- cfg_dist  in  DIST_W  write distance
- cfg_err  out  1  one-cycle pulse on a rejected write
- in_valid  in  1  tour city valid
- in_ready  out  1  engine accepts a city
- in_city  in  CITY_W  city index
- in_last  in  1  final city of the tour
- sum_valid  out  1  tour length available
- sum_ready  in  1  consumer accepts the result
- sum  out  SUM_W  tour length
- sum_sat  out  1  accumulator saturated during this tour
- idx_err  out  1  an illegal index was seen during this tour
- busy  out  1  state ≠ IDLE

Behaviour:
- Table layout:
  - Triangular storage, NUM_CITIES*(NUM_CITIES-1)/2 entries, addr = hi*(hi-1)/2 + lo, where lo = min(a,b) and hi = max(a,b).
  - Each entry has a valid bit; all valid bits clear on reset. Data storage is not reset.
  - Lookup of a==b returns 0. Unwritten entry or illegal index returns DEFAULT_DIST.
- Config writes:
  - Taken when cfg_we=1 and busy=0, effective next cycle.
  - cfg_we with busy=1, a==b, or an illegal index: no write, cfg_err=1 for one cycle.
- Reset values: in_ready=1, sum_valid=0, sum=0, sum_sat=0, idx_err=0, cfg_err=0, busy=0, all table valid bits 0.
- Accept: in_valid && in_ready. in_ready = (state==IDLE || state==ACCUM).
- State machine:
  - IDLE: on accept, store first=prev=in_city, clear sum/sum_sat/idx_err. If in_last, go CLOSE; else go ACCUM.
  - ACCUM: on accept, issue lookup(prev,in_city), set prev=in_city. The table read is synchronous, so the result is added to sum the following cycle. Back-to-back accepts sustain 1 city/cycle. If in_last, go CLOSE.
  - CLOSE (in_ready=0): pending add from the last leg lands; issue lookup(prev,first). Go FLUSH.
  - FLUSH: add the closing distance. Go DONE.
  - DONE: sum_valid=1; sum, sum_sat, idx_err held stable. On sum_ready, go IDLE with sum_valid=0 next cycle.
- Latency: accept of last city → sum_valid asserted 3 cycles later (CLOSE, FLUSH, DONE). Single-city tour: sum=0, same latency.
- Arithmetic: zero-extend each distance to SUM_W. Saturating add: on overflow, sum=all-ones and sum_sat=1. Sticky for the tour.
- Illegal in_city: the city is still accepted, its legs use DEFAULT_DIST, and idx_err=1 sticky for the tour.
- Mid-operation reset: rst_n low in any state immediately returns every output to its reset value and clears the table. Any partial tour is discarded.

Optional Feature:
TDE_EDGE_COUNT_EN:
- Defined: adds output edge_count [15:0], the number of legs summed, including the closing leg. Cleared at tour start, stable in DONE, saturates at 16'hFFFF, reset 0.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, then tour 0,1,2 (last on 2) with nothing written → sum=15 (3×DEFAULT_DIST), sum_valid exactly 3 cycles after the last accept.
- Write (0,1)=9, (1,2)=11, (0,2)=12, then tour 2,0,1 → sum=32. Repeat as 1,0,2 → sum=32 (symmetry).
- Single-city tour 7 with in_last on the first beat → sum=0, sum_sat=0.
- SUM_W=8, write (0,1)=200, tour 0,1 → sum=8'hFF, sum_sat=1. Hold sum_ready=0 for 5 cycles → outputs stable, in_ready=0.
- cfg_we during ACCUM, and cfg_we with a=b=3 → cfg_err pulses, table unchanged. Tour with city 31 → idx_err=1, legs to 31 use 5.
- Assert rst_n low during CLOSE → sum_valid=0 and in_ready=1 immediately. A previously written pair reads DEFAULT_DIST afterward.
